// File: rtl/decode_pkg.sv
// Shared types and constants for the x86 instruction-length decode sequencer:
// FSM states, descriptor layout, prefix bytes and immediate-size helpers.
package decode_pkg;

  localparam int MAX_LEN = 15;

  typedef enum logic [2:0] {
    ST_PFX,
    ST_OPC2,
    ST_MODRM,
    ST_SIB,
    ST_DISP,
    ST_IMM,
    ST_DONE
  } state_t;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_B1   = 2'd1;
  localparam logic [1:0] IMM_B2   = 2'd2;
  localparam logic [1:0] IMM_B4   = 2'd3;

  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ADSZ  = 8'h67;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;
  localparam logic [7:0] ESC_0F    = 8'h0F;

  localparam int PFX_OPSZ_BIT = 6;

  typedef struct packed {
    logic [3:0]  len;
    logic [10:0] pfx_flags;
    logic [7:0]  rex;
    logic        esc;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [63:0] imm;
    logic        err;
  } desc_t;

  // One-hot flag position of a legacy prefix, zero for any other byte.
  function automatic logic [10:0] pfx_bit(input logic [7:0] b);
    case (b)
      PFX_ES:    pfx_bit = 11'h001;
      PFX_CS:    pfx_bit = 11'h002;
      PFX_SS:    pfx_bit = 11'h004;
      PFX_DS:    pfx_bit = 11'h008;
      PFX_FS:    pfx_bit = 11'h010;
      PFX_GS:    pfx_bit = 11'h020;
      PFX_OPSZ:  pfx_bit = 11'h040;
      PFX_ADSZ:  pfx_bit = 11'h080;
      PFX_LOCK:  pfx_bit = 11'h100;
      PFX_REPNE: pfx_bit = 11'h200;
      PFX_REP:   pfx_bit = 11'h400;
      default:   pfx_bit = 11'h000;
    endcase
  endfunction

  // MOV r64, imm64 is the only form carrying eight immediate bytes.
  function automatic logic [3:0] imm_size(input logic [1:0] cls, input logic opsz,
                                          input logic rexw, input logic [7:0] op);
    if (rexw && op[7:3] == 5'b10111) begin
      imm_size = 4'd8;
    end else begin
      case (cls)
        IMM_NONE: imm_size = 4'd0;
        IMM_B1:   imm_size = 4'd1;
        IMM_B2:   imm_size = 4'd2;
        default:  imm_size = (opsz && !rexw) ? 4'd2 : 4'd4;
      endcase
    end
  endfunction

endpackage

// File: rtl/modrm_len.sv
// Combinational ModRM/SIB addressing decode: whether a SIB byte follows and
// how many displacement bytes the addressing form carries.
module modrm_len (
  input  logic [1:0] modrm_mod,
  input  logic [2:0] modrm_rm,
  input  logic [2:0] sib_base,
  input  logic       sib_seen,
  output logic       need_sib,
  output logic [2:0] disp_bytes
);

  always_comb begin
    need_sib   = (modrm_mod != 2'b11) && (modrm_rm == 3'b100);
    disp_bytes = 3'd0;
    case (modrm_mod)
      2'b01: disp_bytes = 3'd1;
      2'b10: disp_bytes = 3'd4;
      2'b00: begin
        // rm=101 is RIP/disp32; SIB base=101 with mod=00 is likewise disp32.
        if (modrm_rm == 3'b101 ||
            (sib_seen && modrm_rm == 3'b100 && sib_base == 3'b101))
          disp_bytes = 3'd4;
      end
      default: disp_bytes = 3'd0;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// Byte-serial x86 instruction-length decoder: walks prefixes, opcode, ModRM,
// SIB, displacement and immediate bytes and emits one descriptor per instruction.
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int MAX_LEN = decode_pkg::MAX_LEN
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  output logic         in_ready,
  input  logic [255:0] modrm_tbl,
  input  logic [511:0] imm_tbl,
  output logic         out_valid,
  input  logic         out_ready,
  output desc_t        out_desc,
  output state_t       dbg_state
);

  // Handshake: a byte transfers on a rising edge with in_valid && in_ready; a
  // descriptor transfers with out_valid && out_ready. in_ready is low whenever
  // out_valid is high, and out_valid/out_desc hold until taken.
  state_t     state;
  logic [3:0] cnt;
  logic [2:0] lane;
  logic [3:0] imm_len;

  logic       accept;
  logic       is_pfx;
  logic       is_rex;
  logic [3:0] op_imm;
  logic [3:0] len_n;
  logic       need_sib;
  logic [2:0] disp_bytes;
  logic [7:0] mr_byte;
  logic       finish;
  logic       overflow;

  assign accept    = in_valid && in_ready;
  assign is_pfx    = |pfx_bit(in_byte);
  assign is_rex    = (in_byte[7:4] == 4'h4);
  assign op_imm    = imm_size(imm_tbl[{in_byte, 1'b0} +: 2], out_desc.pfx_flags[PFX_OPSZ_BIT],
                              out_desc.rex[3], in_byte);
  assign len_n     = out_desc.len + 4'd1;
  assign mr_byte   = (state == ST_MODRM) ? in_byte : out_desc.modrm;
  assign dbg_state = state;

  modrm_len u_modrm_len (
    .modrm_mod  (mr_byte[7:6]),
    .modrm_rm   (mr_byte[2:0]),
    .sib_base   (in_byte[2:0]),
    .sib_seen   (state == ST_SIB),
    .need_sib   (need_sib),
    .disp_bytes (disp_bytes)
  );

  // The accepted byte is the last one of the instruction.
  always_comb begin
    finish = 1'b0;
    if (accept) begin
      case (state)
        ST_PFX:   finish = !is_pfx && !is_rex && (in_byte != ESC_0F) &&
                           !modrm_tbl[in_byte] && (op_imm == 4'd0);
        ST_OPC2:  finish = (in_byte == 8'h05);
        ST_MODRM: finish = !need_sib && (disp_bytes == 3'd0) && (imm_len == 4'd0);
        ST_SIB:   finish = (disp_bytes == 3'd0) && (imm_len == 4'd0);
        ST_DISP:  finish = (cnt == 4'd1) && (imm_len == 4'd0);
        ST_IMM:   finish = (cnt == 4'd1);
        default:  finish = 1'b0;
      endcase
    end
  end

  assign overflow = accept && !finish && (len_n == 4'(MAX_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_PFX;
      out_desc  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      cnt       <= 4'd0;
      lane      <= 3'd0;
      imm_len   <= 4'd0;
    end else if (state == ST_DONE) begin
      if (out_ready) begin
        state     <= ST_PFX;
        out_desc  <= '0;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        cnt       <= 4'd0;
        lane      <= 3'd0;
        imm_len   <= 4'd0;
      end
    end else if (accept) begin
      out_desc.len <= len_n;
      case (state)
        ST_PFX: begin
          if (is_pfx) begin
            out_desc.pfx_flags <= out_desc.pfx_flags | pfx_bit(in_byte);
            out_desc.rex       <= 8'h00;
          end else if (is_rex) begin
            out_desc.rex <= in_byte;
          end else if (in_byte == ESC_0F) begin
            out_desc.esc <= 1'b1;
            state        <= ST_OPC2;
          end else begin
            out_desc.opcode    <= in_byte;
            out_desc.has_modrm <= modrm_tbl[in_byte];
            imm_len            <= op_imm;
            cnt                <= op_imm;
            lane               <= 3'd0;
            state              <= modrm_tbl[in_byte] ? ST_MODRM : ST_IMM;
          end
        end
        ST_OPC2: begin
          out_desc.opcode <= in_byte;
          if (in_byte[7:4] == 4'h8) begin
            imm_len <= 4'd4;
            cnt     <= 4'd4;
            lane    <= 3'd0;
            state   <= ST_IMM;
          end else if (in_byte != 8'h05) begin
            out_desc.has_modrm <= 1'b1;
            state              <= ST_MODRM;
          end
        end
        ST_MODRM, ST_SIB: begin
          if (state == ST_MODRM) out_desc.modrm <= in_byte;
          else                   out_desc.sib   <= in_byte;
          lane <= 3'd0;
          if (state == ST_MODRM && need_sib) begin
            out_desc.has_sib <= 1'b1;
            state            <= ST_SIB;
          end else if (disp_bytes != 3'd0) begin
            cnt   <= {1'b0, disp_bytes};
            state <= ST_DISP;
          end else begin
            cnt   <= imm_len;
            state <= ST_IMM;
          end
        end
        ST_DISP: begin
          out_desc.disp[{lane[1:0], 3'b000} +: 8] <= in_byte;
          if (cnt == 4'd1) begin
            cnt   <= imm_len;
            lane  <= 3'd0;
            state <= ST_IMM;
          end else begin
            cnt  <= cnt - 4'd1;
            lane <= lane + 3'd1;
          end
        end
        ST_IMM: begin
          out_desc.imm[{lane, 3'b000} +: 8] <= in_byte;
          cnt  <= cnt - 4'd1;
          lane <= lane + 3'd1;
        end
        default: state <= ST_PFX;
      endcase
      if (finish || overflow) begin
        state        <= ST_DONE;
        out_valid    <= 1'b1;
        in_ready     <= 1'b0;
        out_desc.err <= overflow;
      end
    end else begin
      in_ready <= 1'b1;
    end
  end

endmodule
